// File: rtl/huffman_dc_dec.sv
// Bit-serial JPEG DC Huffman decoder: size-category code, then magnitude bits, then one signed DC difference.
// Latency: the result is registered on the edge that accepts the last bit of a symbol and is visible the next cycle.
// Backpressure: while a symbol waits for dc_ready, bit_ready is low and no stream bits are consumed.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   is_luminance          table select (1 = luma, 0 = chroma), latched with the first code bit
//   bit_valid/bit_in/bit_ready   one-bit stream input, MSB-first, valid/ready
//   dc_valid/dc_ready     result handshake
//   dc_size, dc_value, dc_err    size category, signed 12-bit difference, invalid-code flag

module huffman_dc_dec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_luminance,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic        bit_ready,
    output logic        dc_valid,
    input  logic        dc_ready,
    output logic [3:0]  dc_size,
    output logic [11:0] dc_value,
    output logic        dc_err
);

    typedef enum logic [1:0] {
        ST_CODE = 2'd0,
        ST_MAG  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t      state;
    logic [10:0] code_q;
    logic [3:0]  len_q;
    logic        luma_q;
    logic [3:0]  mag_cnt_q;
    logic [3:0]  mag_size_q;
    logic [10:0] raw_q;

    // Handshake outputs are pure decodes of the registered state.
    assign bit_ready = (state != ST_OUT);
    assign dc_valid  = (state == ST_OUT);

    logic accept;
    assign accept = bit_valid && bit_ready;

    // ------------------------------------------------------------------
    // Code lookup on the register contents as they will be after this bit
    // ------------------------------------------------------------------
    logic [10:0] code_nxt;
    logic [3:0]  len_nxt;
    logic        tbl_luma;
    logic [10:0] unary_pat;
    logic        hit;
    logic [3:0]  hit_size;
    logic        bad;

    assign code_nxt = {code_q[9:0], bit_in};
    assign len_nxt  = len_q + 4'd1;
    // The first bit of a symbol uses the live select; later bits use the latched one.
    assign tbl_luma = (len_q == 4'd0) ? is_luminance : luma_q;
    // (len-1) ones followed by a zero: the shape of every long code in both tables.
    // At length 11 the shift wraps to zero and the subtraction still yields 11111111110.
    assign unary_pat = (11'd1 << len_nxt) - 11'd2;

    always_comb begin
        hit      = 1'b0;
        hit_size = 4'd0;
        bad      = 1'b0;
        if (tbl_luma) begin
            if (len_nxt == 4'd2) begin
                if (code_nxt[1:0] == 2'b00) begin
                    hit      = 1'b1;
                    hit_size = 4'd0;
                end
            end else if (len_nxt == 4'd3) begin
                case (code_nxt[2:0])
                    3'b010: begin hit = 1'b1; hit_size = 4'd1; end
                    3'b011: begin hit = 1'b1; hit_size = 4'd2; end
                    3'b100: begin hit = 1'b1; hit_size = 4'd3; end
                    3'b101: begin hit = 1'b1; hit_size = 4'd4; end
                    3'b110: begin hit = 1'b1; hit_size = 4'd5; end
                    default: hit = 1'b0;
                endcase
            end else if (len_nxt >= 4'd4 && len_nxt <= 4'd9 && code_nxt == unary_pat) begin
                hit      = 1'b1;
                hit_size = len_nxt + 4'd2;
            end
            bad = !hit && (len_nxt >= 4'd9);
        end else begin
            if (len_nxt == 4'd2) begin
                hit      = 1'b1;
                case (code_nxt[1:0])
                    2'b00:   hit_size = 4'd0;
                    2'b01:   hit_size = 4'd1;
                    2'b10:   hit_size = 4'd2;
                    default: hit      = 1'b0;
                endcase
            end else if (len_nxt >= 4'd3 && len_nxt <= 4'd11 && code_nxt == unary_pat) begin
                hit      = 1'b1;
                hit_size = len_nxt;
            end
            bad = !hit && (len_nxt >= 4'd11);
        end
        // A set top bit means the register outran every legal code; treat as invalid.
        if (code_q[10]) begin
            hit = 1'b0;
            bad = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Magnitude reconstruction
    // ------------------------------------------------------------------
    logic [10:0] raw_nxt;
    logic        raw_msb;
    logic [11:0] raw_ext;
    logic [11:0] neg_offs;
    logic [11:0] mag_val;

    assign raw_nxt  = {raw_q[9:0], bit_in};
    // Leading magnitude bit sits at position size-1; size is never 0 in MAG.
    assign raw_msb  = |(raw_nxt & (11'd1 << (mag_size_q - 4'd1)));
    assign raw_ext  = {1'b0, raw_nxt};
    assign neg_offs = (12'd1 << mag_size_q) - 12'd1;
    // Leading 0 means a negative value: raw - (2^size - 1), wrapping into 12-bit two's complement.
    assign mag_val  = raw_msb ? raw_ext : (raw_ext - neg_offs);

    // ------------------------------------------------------------------
    // State machine and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CODE;
            code_q     <= 11'd0;
            len_q      <= 4'd0;
            luma_q     <= 1'b0;
            mag_cnt_q  <= 4'd0;
            mag_size_q <= 4'd0;
            raw_q      <= 11'd0;
            dc_size    <= 4'd0;
            dc_value   <= 12'd0;
            dc_err     <= 1'b0;
        end else begin
            case (state)
                ST_CODE: begin
                    if (accept) begin
                        code_q <= code_nxt;
                        len_q  <= len_nxt;
                        if (len_q == 4'd0) begin
                            luma_q <= is_luminance;
                        end
                        if (hit) begin
                            if (hit_size == 4'd0) begin
                                dc_size  <= 4'd0;
                                dc_value <= 12'd0;
                                dc_err   <= 1'b0;
                                state    <= ST_OUT;
                            end else begin
                                mag_cnt_q  <= hit_size;
                                mag_size_q <= hit_size;
                                raw_q      <= 11'd0;
                                state      <= ST_MAG;
                            end
                        end else if (bad) begin
                            dc_size  <= 4'd0;
                            dc_value <= 12'd0;
                            dc_err   <= 1'b1;
                            state    <= ST_OUT;
                        end
                    end
                end
                ST_MAG: begin
                    if (accept) begin
                        raw_q     <= raw_nxt;
                        mag_cnt_q <= mag_cnt_q - 4'd1;
                        if (mag_cnt_q == 4'd1) begin
                            dc_size  <= mag_size_q;
                            dc_value <= mag_val;
                            dc_err   <= 1'b0;
                            state    <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (dc_ready) begin
                        code_q <= 11'd0;
                        len_q  <= 4'd0;
                        state  <= ST_CODE;
                    end
                end
                default: begin
                    code_q <= 11'd0;
                    len_q  <= 4'd0;
                    state  <= ST_CODE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_dc_dec.sv
// Directed bench for huffman_dc_dec with hand-computed expected symbols.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Every comparison goes through chk().

module tb_huffman_dc_dec;

    logic        clk;
    logic        rst_n;
    logic        is_luminance;
    logic        bit_valid;
    logic        bit_in;
    logic        bit_ready;
    logic        dc_valid;
    logic        dc_ready;
    logic [3:0]  dc_size;
    logic [11:0] dc_value;
    logic        dc_err;

    int n_checks;
    int n_errors;

    huffman_dc_dec dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .is_luminance (is_luminance),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .bit_ready    (bit_ready),
        .dc_valid     (dc_valid),
        .dc_ready     (dc_ready),
        .dc_size      (dc_size),
        .dc_value     (dc_value),
        .dc_err       (dc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one bit and hold it until an edge accepts it; returns 1 unit after that edge.
    task automatic send_bit(input logic b);
        int guard;
        guard     = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        while (!bit_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!bit_ready) chk("ready_timeout", 16'(bit_ready), 16'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] v, input int n);
        logic [10:0] vv;
        vv = v;
        for (int i = n - 1; i >= 0; i--) send_bit(vv[i]);
    endtask

    // Called right after the final bit's edge with dc_ready=1: checks the OUT cycle and the cycle after.
    task automatic expect_sym(input string tag, input logic [3:0] sz,
                              input logic [11:0] val, input logic err);
        bit_valid = 1'b0;
        chk({tag, "_valid"}, 16'(dc_valid), 16'd1);
        chk({tag, "_size"},  16'(dc_size),  16'(sz));
        chk({tag, "_value"}, 16'(dc_value), 16'(val));
        chk({tag, "_err"},   16'(dc_err),   16'(err));
        chk({tag, "_rdy_lo"}, 16'(bit_ready), 16'd0);
        @(posedge clk);
        #1;
        chk({tag, "_valid_lo"}, 16'(dc_valid), 16'd0);
        chk({tag, "_rdy_hi"},   16'(bit_ready), 16'd1);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        is_luminance = 1'b1;
        bit_valid    = 1'b0;
        bit_in       = 1'b0;
        dc_ready     = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 16'(dc_valid), 16'd0);
        chk("rst_size",  16'(dc_size),  16'd0);
        chk("rst_value", 16'(dc_value), 16'd0);
        chk("rst_err",   16'(dc_err),   16'd0);
        chk("rst_ready", 16'(bit_ready), 16'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Luma size 0: code 00
        send_bits(11'b00, 2);
        expect_sym("luma0", 4'd0, 12'h000, 1'b0);

        // Luma size 3, +5: code 100, magnitude 101
        send_bits(11'b100, 3);
        send_bits(11'b10, 2);
        chk("pos_early_valid", 16'(dc_valid), 16'd0);
        send_bit(1'b1);
        expect_sym("luma_pos5", 4'd3, 12'h005, 1'b0);

        // Luma size 3, -5: code 100, magnitude 010 -> 2 - 7
        send_bits(11'b100, 3);
        send_bits(11'b010, 3);
        expect_sym("luma_neg5", 4'd3, 12'hFFB, 1'b0);

        // Chroma size 11, +1024
        is_luminance = 1'b0;
        send_bits(11'b11111111110, 11);
        send_bits(11'b10000000000, 11);
        expect_sym("chroma_s11", 4'd11, 12'h400, 1'b0);

        // Luma invalid: nine ones
        is_luminance = 1'b1;
        send_bits(11'b111111111, 9);
        expect_sym("luma_err", 4'd0, 12'h000, 1'b1);

        // Fresh symbol after error: code 010 (size 1), magnitude 1
        send_bits(11'b0101, 4);
        expect_sym("after_err", 4'd1, 12'h001, 1'b0);

        // Backpressure on a size-2 symbol: code 011, magnitude 10 -> +2
        send_bits(11'b011, 3);
        send_bit(1'b1);
        dc_ready = 1'b0;
        send_bit(1'b0);
        bit_valid = 1'b1;
        bit_in    = 1'b1;   // first bit of next symbol, held while stalled
        for (int c = 0; c < 3; c++) begin
            chk("bp_valid", 16'(dc_valid), 16'd1);
            chk("bp_size",  16'(dc_size),  16'd2);
            chk("bp_value", 16'(dc_value), 16'h002);
            chk("bp_ready", 16'(bit_ready), 16'd0);
            @(posedge clk);
            #1;
        end
        dc_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 16'(dc_valid), 16'd0);
        chk("bp_release_ready", 16'(bit_ready), 16'd1);

        // Table latched at first bit: luma 110 is size 5 (chroma would be size 3)
        send_bit(1'b1);
        is_luminance = 1'b0;
        send_bits(11'b10, 2);
        send_bits(11'b10000, 5);
        expect_sym("latched_luma", 4'd5, 12'h010, 1'b0);
        is_luminance = 1'b1;

        // Reset mid-magnitude: luma 110 (size 5), two magnitude bits, then reset
        send_bits(11'b110, 3);
        send_bits(11'b10, 2);
        bit_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(dc_valid), 16'd0);
        chk("mid_rst_size",  16'(dc_size),  16'd0);
        chk("mid_rst_value", 16'(dc_value), 16'd0);
        chk("mid_rst_err",   16'(dc_err),   16'd0);
        chk("mid_rst_ready", 16'(bit_ready), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_bits(11'b01111, 5);
        expect_sym("post_rst", 4'd2, 12'h003, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
